// File: rtl/score_store_ctrl_pkg.sv
// Shared types and default game_state codes for the score store controller.
package score_store_ctrl_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    RD,
    CMP,
    WR,
    DONE
  } state_t;

  localparam logic [7:0] DEF_LEVEL_DONE = 8'h20;
  localparam logic [7:0] DEF_GAME_OVER  = 8'h30;

  // Width of a slot index; a single-slot table still needs one bit.
  function automatic int slot_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/score_store_ctrl_id_lookup.sv
// Matches a 4-bit player code against the packed ID table; lowest slot wins on duplicates.
module score_store_ctrl_id_lookup
  import score_store_ctrl_pkg::*;
#(
  parameter int                     NUM_USERS = 4,
  parameter logic [4*NUM_USERS-1:0] ID_TABLE  = {4'b0100, 4'b1101, 4'b0011, 4'b1100},
  parameter int                     SLOT_W    = slot_width(NUM_USERS)
) (
  input  logic [3:0]        user_id,
  output logic              hit,
  output logic [SLOT_W-1:0] slot
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit  = 1'b0;
    slot = '0;
    for (int i = NUM_USERS - 1; i >= 0; i--) begin
      if (ID_TABLE[4*i +: 4] == user_id) begin
        hit  = 1'b1;
        slot = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/score_store_ctrl.sv
// Tracks levels cleared in a game and keeps a per-player best score in an external synchronous RAM.
module score_store_ctrl
  import score_store_ctrl_pkg::*;
#(
  parameter int                     NUM_USERS  = 4,
  parameter int                     DATA_W     = 8,
  parameter int                     ADDR_W     = 8,
  parameter logic [ADDR_W-1:0]      BASE_ADDR  = '0,
  parameter logic [4*NUM_USERS-1:0] ID_TABLE   = {4'b0100, 4'b1101, 4'b0011, 4'b1100},
  parameter logic [7:0]             LEVEL_DONE = DEF_LEVEL_DONE,
  parameter logic [7:0]             GAME_OVER  = DEF_GAME_OVER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        user_id,
  input  logic [7:0]        game_state,
  input  logic              clear_all,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] cur_level,
  output logic [DATA_W-1:0] best_level,
  output logic              new_record,
  output logic              user_valid,
  output logic              busy
);

  localparam int               SLOT_W   = slot_width(NUM_USERS);
  localparam int               CNT_W    = $clog2(NUM_USERS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_USERS);

  state_t            state;
  logic [7:0]        prev_gs;
  logic [CNT_W-1:0]  clr_cnt;
  logic [SLOT_W-1:0] lookup_slot;
  logic              level_rise;
  logic              over_rise;
  logic              start_clear;

  score_store_ctrl_id_lookup #(
    .NUM_USERS(NUM_USERS),
    .ID_TABLE (ID_TABLE),
    .SLOT_W   (SLOT_W)
  ) u_id_lookup (
    .user_id(user_id),
    .hit    (user_valid),
    .slot   (lookup_slot)
  );

  assign level_rise  = (game_state == LEVEL_DONE) && (prev_gs != LEVEL_DONE);
  assign over_rise   = (game_state == GAME_OVER) && (prev_gs != GAME_OVER);
  assign start_clear = clear_all && ((state == IDLE) || (state == DONE));
  assign busy        = (state == CLEAR) || (state == RD) || (state == CMP) || (state == WR);

  // RAM strobes are registered one state ahead, so a clear_all entry writes slot 0 on its first CLEAR cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      cur_level  <= '0;
      best_level <= '0;
      new_record <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= BASE_ADDR;
      ram_wdata  <= '0;
      prev_gs    <= '0;
    end else begin
      prev_gs <= game_state;
      if (start_clear) begin
        state     <= CLEAR;
        cur_level <= '0;
        ram_we    <= 1'b1;
        ram_wdata <= '0;
        ram_addr  <= BASE_ADDR;
        clr_cnt   <= CNT_W'(1);
      end else begin
        case (state)
          CLEAR: begin
            if (clr_cnt == CNT_LAST) begin
              state    <= IDLE;
              clr_cnt  <= '0;
              ram_we   <= 1'b0;
              ram_addr <= BASE_ADDR;
            end else begin
              ram_we    <= 1'b1;
              ram_wdata <= '0;
              ram_addr  <= BASE_ADDR + ADDR_W'(clr_cnt);
              clr_cnt   <= clr_cnt + 1'b1;
            end
          end
          IDLE: begin
            if (over_rise) begin
              if (user_valid) begin
                state    <= RD;
                ram_we   <= 1'b0;
                ram_addr <= BASE_ADDR + ADDR_W'(lookup_slot);
              end else begin
                state      <= DONE;
                best_level <= '0;
                new_record <= 1'b0;
              end
            end else if (level_rise && (cur_level != '1)) begin
              cur_level <= cur_level + 1'b1;
            end
          end
          RD: state <= CMP;
          CMP: begin
            if (cur_level > ram_rdata) begin
              state     <= WR;
              ram_we    <= 1'b1;
              ram_wdata <= cur_level;
            end else begin
              state      <= DONE;
              best_level <= ram_rdata;
              new_record <= 1'b0;
            end
          end
          WR: begin
            state      <= DONE;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            best_level <= cur_level;
            new_record <= 1'b1;
          end
          DONE: begin
            if (game_state != GAME_OVER) begin
              state      <= IDLE;
              cur_level  <= '0;
              new_record <= 1'b0;
            end
          end
          default: state <= CLEAR;
        endcase
      end
    end
  end

endmodule

// File: doc/score_store_ctrl.md
SCORE_STORE_CTRL -- requirements
Module: score_store_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_USERS, 4, number of score slots; DATA_W, 8, level/score width; ADDR_W, 8, RAM address width; BASE_ADDR, 0, address of slot 0; ID_TABLE, {4'b0100,4'b1101,4'b0011,4'b1100}, NUM_USERS packed 4-bit user codes with slot i in bits [4i+3:4i].
REQ-002 Parameters SHALL also be: LEVEL_DONE, 8'h20, game_state code for level complete; GAME_OVER, 8'h30, game_state code for game end.
REQ-003 Ports SHALL be: clk  in  1  single clock, all logic on rising edge.
REQ-004 Ports SHALL be: reset  in  1  asynchronous, active-low reset.
REQ-005 Ports SHALL be: user_id  in  4  current player code; game_state  in  8  controller state code; clear_all  in  1  request to zero all slots.
REQ-006 Ports SHALL be: ram_rdata  in  DATA_W  synchronous RAM read data, valid one cycle after address.
REQ-007 Ports SHALL be: ram_addr  out  ADDR_W; ram_we  out  1  1=write, 0=read; ram_wdata  out  DATA_W.
REQ-008 Ports SHALL be: cur_level  out  DATA_W  levels cleared this game; best_level  out  DATA_W  stored best after game over; new_record  out  1; user_valid  out  1  user_id matches ID_TABLE; busy  out  1  high in CLEAR/RD/CMP/WR.

Function
REQ-009 FSM states SHALL be CLEAR, IDLE, RD, CMP, WR, DONE.
REQ-010 CLEAR SHALL write 0 to BASE_ADDR+0 .. BASE_ADDR+NUM_USERS-1, one slot per cycle with ram_we=1, then enter IDLE; duration exactly NUM_USERS cycles.
REQ-011 In IDLE, cur_level SHALL increment by 1 once per rising entry into game_state==LEVEL_DONE (previous-cycle value differs), not per cycle held.
REQ-012 cur_level SHALL saturate at 2^DATA_W-1; no wrap.
REQ-013 user_valid SHALL be combinational match of user_id against ID_TABLE; slot index SHALL be the matching entry, lowest index on duplicates.
REQ-014 On rising entry into GAME_OVER in IDLE with user_valid=1, FSM SHALL latch slot, drive ram_addr=BASE_ADDR+slot, ram_we=0, enter RD.
REQ-015 RD SHALL wait one cycle; CMP SHALL compare ram_rdata with cur_level.
REQ-016 If cur_level > ram_rdata, CMP SHALL enter WR: one cycle ram_we=1, ram_wdata=cur_level, best_level<=cur_level, new_record<=1; then DONE.
REQ-017 Otherwise CMP SHALL set best_level<=ram_rdata, new_record<=0, enter DONE with no write.
REQ-018 GAME_OVER entry with user_valid=0 SHALL go straight to DONE, best_level<=0, new_record<=0, no RAM access.
REQ-019 DONE SHALL hold best_level/new_record until game_state!=GAME_OVER, then clear cur_level and new_record and return to IDLE.
REQ-020 clear_all SHALL be honoured only in IDLE or DONE (enters CLEAR, cur_level<=0); ignored while busy.
REQ-021 clear_all and GAME_OVER entry in the same IDLE cycle: clear_all SHALL win.
REQ-022 ram_we SHALL be 1 only in CLEAR and WR; ram_wdata SHALL be 0 whenever ram_we=0.

Reset
REQ-023 Asserted reset SHALL immediately force state=CLEAR, slot counter=0, cur_level=0, best_level=0, new_record=0, ram_we=0, ram_addr=BASE_ADDR.
REQ-024 Reset mid-write SHALL abandon the operation; CLEAR re-initialises all slots after release.

Structure
REQ-025 A shared package SHALL hold the state enumeration and default LEVEL_DONE/GAME_OVER codes.
REQ-026 An id_lookup sub-module SHALL implement the ID_TABLE match (user_valid, slot index).

Verification
REQ-027 Reset release, defaults -> ram_we=1 for exactly 4 cycles at addresses 0..3 with wdata 0, then busy=0.
REQ-028 user 4'b0011, three LEVEL_DONE pulses each held 5 cycles, then GAME_OVER -> cur_level=3, read addr 1, write 3 to addr 1, best_level=3, new_record=1.
REQ-029 Same user, game with 2 levels -> no write, best_level=3, new_record=0.
REQ-030 DATA_W=2, five LEVEL_DONE entries -> cur_level saturates at 3.
REQ-031 user 4'b1111 at GAME_OVER -> user_valid=0, no RAM access, best_level=0.
REQ-032 reset asserted during WR, clear_all during RD -> immediate reset values; clear_all ignored until DONE.
